// File: rtl/tm_pkg.sv
// Shared defaults, requester indices and small helpers for the Turing-machine
// memory arbiter.
package tm_pkg;

    localparam int TM_DW = 4;
    localparam int TM_W  = 64;
    localparam int TM_AW = $clog2(TM_W);

    // Fixed requester slots used by the step-sequencing datapath.
    localparam int REQ_INPUT = 0;
    localparam int REQ_RULE  = 1;
    localparam int REQ_TAPE  = 2;

    typedef enum logic {
        LOCK_FREE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    function automatic int next_index(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/tm_mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: flattened per-requester request
// fields plus the one-hot grant and read-return channel.
interface tm_mem_arbiter_if
    import tm_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = TM_DW,
    parameter int AW = TM_AW
);

    logic [N-1:0]    req;
    logic [N-1:0]    req_we;
    logic [N-1:0]    req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;

    modport master (
        output req, req_we, req_lock, req_addr, req_wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, req_we, req_lock, req_addr, req_wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of req scanning from ptr upward,
// wrapping modulo N. Purely combinational.
module rr_pick
    import tm_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    always_comb begin
        int   cand;
        logic found;
        // NOTE: every output gets a default before the loop, so no path leaves
        // a value unassigned and no latch is inferred.
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/tm_mem_arbiter.sv
// Round-robin arbiter sharing the single-port tape/rule memory between N
// requesters, with an optional ownership lock and a 1-cycle read return.
module tm_mem_arbiter
    import tm_pkg::*;
#(
    parameter  int N  = 3,
    parameter  int DW = TM_DW,
    parameter  int W  = TM_W,
    parameter  int AW = $clog2(W),
    localparam int IW = $clog2(N)
) (
    input  logic                  clock,
    input  logic                  reset,
    tm_mem_arbiter_if.slave       bus,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata,
    output logic                  owner_valid,
    output logic [IW-1:0]         owner_id
);

    lock_state_e   lock_q, lock_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  rd_q, rd_d;

    logic [N-1:0]  owner_mask;
    logic [N-1:0]  eligible;
    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          granted;
    logic          win_we;
    logic          win_lock;

    // While locked only the owner may compete; the picker still rotates from
    // ptr, but with a single candidate the pointer cannot change the outcome.
    assign owner_mask = {{(N-1){1'b0}}, 1'b1} << owner_q;
    assign eligible   = (lock_q == LOCK_HELD) ? (bus.req & owner_mask) : bus.req;

    rr_pick #(.N(N)) u_pick (
        .req    (eligible),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    assign granted  = |pick_onehot;
    assign win_we   = bus.req_we[pick_idx];
    assign win_lock = bus.req_lock[pick_idx];
    assign bus.gnt  = pick_onehot;

    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (granted) begin
            mem_we    = win_we;
            mem_re    = ~win_we;
            mem_addr  = bus.req_addr[int'(pick_idx)*AW +: AW];
            mem_wdata = bus.req_wdata[int'(pick_idx)*DW +: DW];
        end
    end

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        rd_d    = '0;
        if (granted) begin
            ptr_d = IW'(next_index(int'(pick_idx), N));
            if (!win_we) begin
                rd_d = pick_onehot;
            end
            // A grant while locked can only go to the owner, so dropping
            // req_lock here is always the owner releasing.
            if (win_lock) begin
                lock_d  = LOCK_HELD;
                owner_d = pick_idx;
            end else if (lock_q == LOCK_HELD) begin
                lock_d  = LOCK_FREE;
                owner_d = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            lock_q  <= LOCK_FREE;
            owner_q <= '0;
            ptr_q   <= '0;
            rd_q    <= '0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            rd_q    <= rd_d;
        end
    end

    assign owner_valid = (lock_q == LOCK_HELD);
    assign owner_id    = owner_q;
    assign bus.rvalid  = rd_q;
    assign bus.rdata   = (|rd_q) ? mem_rdata : '0;

    gnt_onehot_a: assert property (@(posedge clock) disable iff (reset)
        $onehot0(pick_onehot));

    lock_exclusive_a: assert property (@(posedge clock) disable iff (reset)
        (lock_q == LOCK_HELD) |-> ((pick_onehot & ~owner_mask) == '0));

endmodule

// File: tb/tb_tm_mem_arbiter.sv
// Self-checking bench for tm_mem_arbiter: reference grant/lock model, memory
// model, and a read-return scoreboard, plus directed lock/reset scenarios.
module tb_tm_mem_arbiter;
    import tm_pkg::*;

    localparam int N  = 3;
    localparam int DW = TM_DW;
    localparam int W  = TM_W;
    localparam int AW = TM_AW;
    localparam int IW = $clog2(N);

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          owner_valid;
    logic [IW-1:0] owner_id;

    tm_mem_arbiter_if #(.N(N), .DW(DW), .AW(AW)) bus ();

    tm_mem_arbiter #(.N(N), .DW(DW), .W(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.slave),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .owner_valid (owner_valid),
        .owner_id    (owner_id)
    );

    always #5 clock = ~clock;

    // Single-port memory with registered read data.
    logic [DW-1:0] mem [W];
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state (updated once per cycle at the sampling edge).
    logic [DW-1:0] ref_mem [W];
    rd_exp_t       sb_q[$];
    int            m_ptr = 0;
    logic          m_lock = 1'b0;
    int            m_owner = 0;
    logic [N-1:0]  m_last_gnt = '0;
    int            waits [N];
    bit            rand_phase = 1'b0;

    always @(negedge clock) begin : monitor
        logic [2*N-1:0] dbl;
        logic [N-1:0]   eg;
        logic [AW-1:0]  a;
        logic [DW-1:0]  wd;
        rd_exp_t        e;
        int             w;

        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("rvalid", 32'(bus.rvalid), 32'(1) << e.id);
            check("rdata", 32'(bus.rdata), 32'(e.data));
        end else begin
            check("rvalid_idle", 32'(bus.rvalid), 32'(0));
        end
        check("owner_valid", 32'(owner_valid), 32'(m_lock));
        check("owner_id", 32'(owner_id), m_lock ? 32'(m_owner) : 32'(0));

        w = -1;
        if (m_lock) begin
            if (bus.req[m_owner]) w = m_owner;
        end else begin
            dbl = {bus.req, bus.req} >> m_ptr;
            for (int p = N - 1; p >= 0; p--)
                if (dbl[p]) w = (m_ptr + p) % N;
        end
        eg = '0;
        a  = '0;
        wd = '0;
        if (w >= 0) begin
            eg[w] = 1'b1;
            a     = bus.req_addr[w*AW +: AW];
            wd    = bus.req_wdata[w*DW +: DW];
        end
        check("gnt", 32'(bus.gnt), 32'(eg));
        check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'(1));
        if (w >= 0) begin
            check("mem_we", 32'(mem_we), 32'(bus.req_we[w]));
            check("mem_re", 32'(mem_re), 32'(!bus.req_we[w]));
            check("mem_addr", 32'(mem_addr), 32'(a));
            check("mem_wdata", 32'(mem_wdata), 32'(wd));
        end else begin
            check("mem_idle", {mem_re, mem_we, 30'(mem_addr), 30'(0)} | 32'(mem_wdata), 32'(0));
        end

        if (rand_phase) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) begin
                    if (bus.gnt[i]) begin
                        check("fair_wait", 32'(waits[i] < N), 32'(1));
                        waits[i] = 0;
                    end else begin
                        waits[i]++;
                        if (waits[i] >= N) check("fair_timeout", 32'(waits[i]), 32'(N - 1));
                    end
                end else begin
                    waits[i] = 0;
                end
            end
        end

        if (w >= 0 && bus.req_we[w]) ref_mem[a] = wd;
        if (reset) begin
            m_ptr   = 0;
            m_lock  = 1'b0;
            m_owner = 0;
            sb_q.delete();
        end else if (w >= 0) begin
            if (!bus.req_we[w]) sb_q.push_back('{w, ref_mem[a]});
            m_ptr = (w + 1) % N;
            if (bus.req_lock[w]) begin
                m_lock  = 1'b1;
                m_owner = w;
            end else begin
                m_lock  = 1'b0;
                m_owner = 0;
            end
        end
        m_last_gnt = eg;
    end

    task automatic idle_inputs();
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic drive(input int i, input logic we, input logic lock,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bus.req[i]                = 1'b1;
        bus.req_we[i]             = we;
        bus.req_lock[i]           = lock;
        bus.req_addr[i*AW +: AW]  = addr;
        bus.req_wdata[i*DW +: DW] = wd;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < W; i++) begin
            mem[i]     = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end
        for (int i = 0; i < N; i++) waits[i] = 0;
        idle_inputs();
        reset = 1'b1;

        // Reset state with no requests.
        @(negedge clock);
        check("rst_gnt", 32'(bus.gnt), 32'(0));
        check("rst_rvalid", 32'(bus.rvalid), 32'(0));
        check("rst_owner", 32'(owner_valid), 32'(0));
        check("rst_mem_re", 32'(mem_re), 32'(0));
        next_cycle();
        reset = 1'b0;

        // All three read addrs 5/6/7: rotation 001,010,100,001.
        drive(REQ_INPUT, 1'b0, 1'b0, 6'd5, 4'h0);
        drive(REQ_RULE,  1'b0, 1'b0, 6'd6, 4'h0);
        drive(REQ_TAPE,  1'b0, 1'b0, 6'd7, 4'h0);
        @(negedge clock);
        check("rr_gnt0", 32'(bus.gnt), 32'b001);
        next_cycle();
        @(negedge clock);
        check("rr_gnt1", 32'(bus.gnt), 32'b010);
        check("rr_rv0", 32'(bus.rvalid), 32'b001);
        check("rr_rd0", 32'(bus.rdata), 32'h6);
        next_cycle();
        @(negedge clock);
        check("rr_gnt2", 32'(bus.gnt), 32'b100);
        check("rr_rv1", 32'(bus.rvalid), 32'b010);
        check("rr_rd1", 32'(bus.rdata), 32'hD);
        next_cycle();
        @(negedge clock);
        check("rr_gnt3", 32'(bus.gnt), 32'b001);
        check("rr_rv2", 32'(bus.rvalid), 32'b100);
        check("rr_rd2", 32'(bus.rdata), 32'h4);
        next_cycle();
        idle_inputs();
        @(negedge clock);
        check("rr_idle_gnt", 32'(bus.gnt), 32'(0));
        check("rr_rv3", 32'(bus.rvalid), 32'b001);

        // Tape writes 0xA to addr 9, input port reads it back.
        next_cycle();
        drive(REQ_TAPE, 1'b1, 1'b0, 6'd9, 4'hA);
        @(negedge clock);
        check("wr_gnt", 32'(bus.gnt), 32'b100);
        check("wr_mem_we", 32'(mem_we), 32'(1));
        next_cycle();
        idle_inputs();
        drive(REQ_INPUT, 1'b0, 1'b0, 6'd9, 4'h0);
        @(negedge clock);
        check("wr_rd_gnt", 32'(bus.gnt), 32'b001);
        check("wr_no_rvalid", 32'(bus.rvalid), 32'(0));
        next_cycle();
        idle_inputs();
        @(negedge clock);
        check("wr_rv", 32'(bus.rvalid), 32'b001);
        check("wr_rdata", 32'(bus.rdata), 32'hA);

        // Tape locks for read-then-rewrite of addr 3 while input waits.
        next_cycle();
        drive(REQ_TAPE,  1'b0, 1'b1, 6'd3, 4'h0);
        drive(REQ_INPUT, 1'b0, 1'b0, 6'd3, 4'h0);
        @(negedge clock);
        check("lk_gnt_a", 32'(bus.gnt), 32'b100);
        next_cycle();
        drive(REQ_TAPE, 1'b1, 1'b0, 6'd3, 4'hC);
        @(negedge clock);
        check("lk_gnt_b", 32'(bus.gnt), 32'b100);
        check("lk_owner_v", 32'(owner_valid), 32'(1));
        check("lk_owner_id", 32'(owner_id), 32'(REQ_TAPE));
        check("lk_rdata", 32'(bus.rdata), 32'h8);
        next_cycle();
        bus.req[REQ_TAPE] = 1'b0;
        @(negedge clock);
        check("lk_rel_gnt", 32'(bus.gnt), 32'b001);
        check("lk_rel_owner", 32'(owner_valid), 32'(0));
        next_cycle();
        idle_inputs();
        @(negedge clock);
        check("lk_rewrite", 32'(bus.rdata), 32'hC);

        // Rule port holds the lock while idle; input must stall.
        next_cycle();
        drive(REQ_RULE, 1'b0, 1'b1, 6'd10, 4'h0);
        @(negedge clock);
        check("hold_gnt", 32'(bus.gnt), 32'b010);
        next_cycle();
        idle_inputs();
        drive(REQ_INPUT, 1'b0, 1'b0, 6'd11, 4'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("hold_stall_gnt", 32'(bus.gnt), 32'(0));
            check("hold_mem", 32'({mem_re, mem_we}), 32'(0));
            check("hold_owner", 32'(owner_valid), 32'(1));
            check("hold_owner_id", 32'(owner_id), 32'(REQ_RULE));
            if (c == 0) check("hold_rdata", 32'(bus.rdata), 32'h9);
            next_cycle();
        end
        drive(REQ_RULE, 1'b0, 1'b0, 6'd12, 4'h0);
        @(negedge clock);
        check("hold_rel_gnt", 32'(bus.gnt), 32'b010);
        next_cycle();
        bus.req[REQ_RULE] = 1'b0;
        @(negedge clock);
        check("hold_after_gnt", 32'(bus.gnt), 32'b001);

        // Locked read granted to rule port in the same cycle as reset.
        next_cycle();
        idle_inputs();
        drive(REQ_RULE, 1'b0, 1'b1, 6'd20, 4'h0);
        reset = 1'b1;
        @(negedge clock);
        check("rst_cyc_gnt", 32'(bus.gnt), 32'b010);
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        drive(REQ_INPUT, 1'b0, 1'b0, 6'd1, 4'h0);
        drive(REQ_RULE,  1'b0, 1'b0, 6'd2, 4'h0);
        drive(REQ_TAPE,  1'b0, 1'b0, 6'd4, 4'h0);
        @(negedge clock);
        check("rst_cyc_rvalid", 32'(bus.rvalid), 32'(0));
        check("rst_cyc_owner", 32'(owner_valid), 32'(0));
        check("rst_cyc_ptr", 32'(bus.gnt), 32'b001);
        next_cycle();
        idle_inputs();

        // Random unlocked traffic; requests are held until granted.
        rand_phase = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            next_cycle();
            for (int i = 0; i < N; i++) begin
                if (!(bus.req[i] && !m_last_gnt[i])) begin
                    if ($urandom_range(0, 2) != 0)
                        drive(i, 1'($urandom_range(0, 1)), 1'b0,
                              AW'($urandom_range(0, W - 1)), DW'($urandom_range(0, 15)));
                    else
                        bus.req[i] = 1'b0;
                end
            end
        end
        next_cycle();
        rand_phase = 1'b0;
        idle_inputs();
        repeat (3) next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
